// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//
// Purpose:
//   Bit-serial adder with a small control FSM. One 1-bit full-adder slice and
//   a carry register process the operands LSB first, one bit per clock. A
//   complete addition of two WIDTH-bit operands takes WIDTH cycles in RUN plus
//   one cycle in DONE, so a new operation can be accepted every WIDTH+2 cycles.
//
// Parameters:
//   WIDTH   operand width in bits (legal range 2..32), default 8
//
// Ports:
//   i_clk    in   1      clock, all state changes on the rising edge
//   i_rst    in   1      synchronous active-high reset
//   i_start  in   1      request to begin one addition (honoured in IDLE only)
//   i_a      in   WIDTH  operand A, captured when a start is accepted
//   i_b      in   WIDTH  operand B, captured when a start is accepted
//   i_cin    in   1      carry-in, captured when a start is accepted
//   o_sum    out  WIDTH  registered sum, held until the next result
//   o_cout   out  1      registered carry out of the MSB, held with o_sum
//   o_busy   out  1      high while bits are being added (state RUN)
//   o_done   out  1      one-cycle pulse marking a new o_sum/o_cout (state DONE)
//   o_ovf    out  1      signed overflow, held with o_sum
//                        (present only when SERIAL_ADD_OVF_EN is defined)
//
// Configuration:
//   SERIAL_ADD_OVF_EN  define to add the o_ovf output and its capture logic.
//                      Without it the port and logic are absent and all other
//                      behaviour is identical.
// ---------------------------------------------------------------------------
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_busy,
  output logic             o_done
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             o_ovf
`endif
);

  // Counter only needs to reach WIDTH-1, the index of the last bit.
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic sum_bit;
  logic carry_nxt;
  logic last_bit;
  logic start_accept;

  // The single full-adder slice: always looks at the current LSBs of the
  // operand shift registers and the running carry.
  assign sum_bit   = a_sr[0] ^ b_sr[0] ^ carry;
  assign carry_nxt = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);

  assign last_bit     = (cnt == LAST_BIT);
  assign start_accept = (state == IDLE) && i_start;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and status outputs. busy/done decode directly from the state
  // register, so they are glitch-free and aligned with the state.
  always_comb begin
    state_nxt = state;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        o_busy = 1'b1;
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture and bit-serial datapath. Operands are copied into
  // private shift registers at acceptance so that later input changes do not
  // disturb the operation in progress.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (start_accept) begin
      a_sr   <= i_a;
      b_sr   <= i_b;
      res_sr <= '0;
      carry  <= i_cin;
      cnt    <= '0;
    end else if (state == RUN) begin
      // Sum bits enter at the MSB, so after WIDTH shifts bit 0 of the result
      // has reached bit 0 of the register.
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      res_sr <= {sum_bit, res_sr[WIDTH-1:1]};
      carry  <= carry_nxt;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // Result registers. Updated only on the edge that processes the MSB, so
  // they hold the previous result for the whole of RUN. The final sum word
  // is assembled from the shift register plus the bit being produced now.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sum  <= '0;
      o_cout <= 1'b0;
    end else if ((state == RUN) && last_bit) begin
      o_sum  <= {sum_bit, res_sr[WIDTH-1:1]};
      o_cout <= carry_nxt;
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  // While the MSB is being processed the carry register holds the carry into
  // the MSB, so overflow is that carry XOR the carry leaving the MSB.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ovf <= 1'b0;
    end else if ((state == RUN) && last_bit) begin
      o_ovf <= carry ^ carry_nxt;
    end
  end
`endif

endmodule
